// File: rtl/arcade_video_pkg.sv
// Shared defaults, DW=8 colour-bar table and sync-start clamp helper for arcade_video_timing.
package arcade_video_pkg;

   localparam int DEF_H_ACTIVE = 288;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 32;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 224;
   localparam int DEF_V_FP     = 16;
   localparam int DEF_V_SYNC   = 8;
   localparam int DEF_V_BP     = 16;
   localparam int DEF_CE_DIV   = 4;
   localparam int DEF_DW       = 8;

   typedef logic [9:0] pos_t;

   // 3R3G2B bars: white, yellow, cyan, green, magenta, red, blue, black.
   function automatic logic [7:0] bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    bar_colour = 8'hFF;
         3'd1:    bar_colour = 8'hFC;
         3'd2:    bar_colour = 8'h1F;
         3'd3:    bar_colour = 8'h1C;
         3'd4:    bar_colour = 8'hE3;
         3'd5:    bar_colour = 8'hE0;
         3'd6:    bar_colour = 8'h03;
         default: bar_colour = 8'h00;
      endcase
   endfunction

   function automatic pos_t clamp_start(input pos_t base, input logic [3:0] offset,
                                        input pos_t lo, input pos_t hi);
      logic signed [11:0] sum_s;
      sum_s = $signed({2'b00, base}) + $signed({{8{offset[3]}}, offset});
      if (sum_s < $signed({2'b00, lo})) begin
         clamp_start = lo;
      end else if (sum_s > $signed({2'b00, hi})) begin
         clamp_start = hi;
      end else begin
         clamp_start = sum_s[9:0];
      end
   endfunction

endpackage

// File: rtl/arcade_ce_div.sv
// Pixel-clock divider: counts 0..CE_DIV-1; ce is a registered flag that is high
// while the count sits at CE_DIV-1, i.e. on the clock whose edge is a pixel step.
module arcade_ce_div
   import arcade_video_pkg::*;
#(
   parameter int CE_DIV = DEF_CE_DIV
) (
   input  logic clk_video,
   input  logic reset,
   output logic ce
);

   localparam int               DIV_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
   localparam logic             CE_RST   = (CE_DIV == 1) ? 1'b1 : 1'b0;

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;
   logic             ce_q;

   // Next divider count with wrap at CE_DIV-1.
   always_comb begin
      if (div_q == DIV_LAST) begin
         div_d = {DIV_W{1'b0}};
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // ce mirrors "count is at terminal" so CE_DIV=1 steps on every edge.
   always_ff @(posedge clk_video) begin
      if (reset) begin
         div_q <= {DIV_W{1'b0}};
         ce_q  <= CE_RST;
      end else begin
         div_q <= div_d;
         ce_q  <= (div_d == DIV_LAST);
      end
   end

   assign ce = ce_q;

endmodule

// File: rtl/arcade_video_timing.sv
// Arcade raster timing generator with per-frame sync offsets and RGB blanking.
// Optional colour bars are built only with `define ARCADE_VIDEO_TESTPAT_EN.
module arcade_video_timing
   import arcade_video_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int CE_DIV   = DEF_CE_DIV,
   parameter int DW       = DEF_DW
) (
   input  logic          clk_video,
   input  logic          reset,
   input  logic [3:0]    hoffset,
   input  logic [3:0]    voffset,
   input  logic [DW-1:0] RGB_in,
   input  logic          test_en,
   output logic          ce_pix,
   output logic [8:0]    hcount,
   output logic [8:0]    vcount,
   output logic          HBlank,
   output logic          VBlank,
   output logic          HSync,
   output logic          VSync,
   output logic          frame_start,
   output logic [DW-1:0] RGB_out
);

   localparam int         H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
   localparam pos_t       H_ACT_P  = pos_t'(H_ACTIVE);
   localparam pos_t       V_ACT_P  = pos_t'(V_ACTIVE);
   localparam pos_t       HS_BASE  = pos_t'(H_ACTIVE + H_FP);
   localparam pos_t       VS_BASE  = pos_t'(V_ACTIVE + V_FP);
   localparam pos_t       HS_HI    = pos_t'(H_TOTAL - H_SYNC);
   localparam pos_t       VS_HI    = pos_t'(V_TOTAL - V_SYNC);
   localparam pos_t       H_SYNC_P = pos_t'(H_SYNC);
   localparam pos_t       V_SYNC_P = pos_t'(V_SYNC);

   logic          step_s;
   logic [8:0]    hcount_q, hcount_d;
   logic [8:0]    vcount_q, vcount_d;
   logic [3:0]    hoff_q, hoff_d;
   logic [3:0]    voff_q, voff_d;
   logic          ce_pix_q;
   logic          hblank_q, hblank_d;
   logic          vblank_q, vblank_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          frame_start_q, frame_start_d;
   logic [DW-1:0] rgb_q, rgb_d;
   logic [DW-1:0] pix_s;
   pos_t          hs_start_s;
   pos_t          vs_start_s;

   arcade_ce_div #(
      .CE_DIV    (CE_DIV)
   ) u_ce_div (
      .clk_video (clk_video),
      .reset     (reset),
      .ce        (step_s)
   );

   // Offsets only change at the frame wrap, where position (0,0) is never in sync.
   assign hs_start_s = clamp_start(HS_BASE, hoff_q, H_ACT_P, HS_HI);
   assign vs_start_s = clamp_start(VS_BASE, voff_q, V_ACT_P, VS_HI);

`ifdef ARCADE_VIDEO_TESTPAT_EN
   localparam int         BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
   localparam logic [8:0] BAR_W_P = 9'(BAR_W);

   logic [8:0] bar_idx_s;
   logic [2:0] bar_sel_s;

   // Pixel source: bar colour for the upcoming column when test_en is set.
   always_comb begin
      bar_idx_s = hcount_d / BAR_W_P;
      if (bar_idx_s > 9'd7) begin
         bar_sel_s = 3'd7;
      end else begin
         bar_sel_s = bar_idx_s[2:0];
      end
      if (test_en) begin
         pix_s = DW'(bar_colour(bar_sel_s));
      end else begin
         pix_s = RGB_in;
      end
   end
`else
   logic unused_test_en_s;

   assign unused_test_en_s = test_en;
   assign pix_s            = RGB_in;
`endif

   // Raster advance and next values of every timed output, held between steps.
   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      hoff_d        = hoff_q;
      voff_d        = voff_q;
      hblank_d      = hblank_q;
      vblank_d      = vblank_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      frame_start_d = frame_start_q;
      rgb_d         = rgb_q;
      if (step_s) begin
         if (hcount_q == H_LAST) begin
            hcount_d = 9'd0;
            if (vcount_q == V_LAST) begin
               vcount_d = 9'd0;
               hoff_d   = hoffset;
               voff_d   = voffset;
            end else begin
               vcount_d = vcount_q + 9'd1;
            end
         end else begin
            hcount_d = hcount_q + 9'd1;
         end
         hblank_d      = ({1'b0, hcount_d} >= H_ACT_P);
         vblank_d      = ({1'b0, vcount_d} >= V_ACT_P);
         hsync_d       = ({1'b0, hcount_d} >= hs_start_s) &&
                         ({1'b0, hcount_d} <  (hs_start_s + H_SYNC_P));
         vsync_d       = ({1'b0, vcount_d} >= vs_start_s) &&
                         ({1'b0, vcount_d} <  (vs_start_s + V_SYNC_P));
         frame_start_d = (hcount_d == 9'd0) && (vcount_d == 9'd0);
         if (!hblank_d && !vblank_d) begin
            rgb_d = pix_s;
         end else begin
            rgb_d = {DW{1'b0}};
         end
      end else begin
         hcount_d = hcount_q;
         rgb_d    = rgb_q;
      end
   end

   // State and output registers; ce_pix follows the divider every clock.
   always_ff @(posedge clk_video) begin
      if (reset) begin
         ce_pix_q      <= 1'b0;
         hcount_q      <= 9'd0;
         vcount_q      <= 9'd0;
         hoff_q        <= 4'd0;
         voff_q        <= 4'd0;
         hblank_q      <= 1'b0;
         vblank_q      <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         frame_start_q <= 1'b0;
         rgb_q         <= {DW{1'b0}};
      end else begin
         ce_pix_q      <= step_s;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hoff_q        <= hoff_d;
         voff_q        <= voff_d;
         hblank_q      <= hblank_d;
         vblank_q      <= vblank_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
         rgb_q         <= rgb_d;
      end
   end

   assign ce_pix      = ce_pix_q;
   assign hcount      = hcount_q;
   assign vcount      = vcount_q;
   assign HBlank      = hblank_q;
   assign VBlank      = vblank_q;
   assign HSync       = hsync_q;
   assign VSync       = vsync_q;
   assign frame_start = frame_start_q;
   assign RGB_out     = rgb_q;

endmodule

// File: tb/tb_arcade_video_timing.sv
// Randomized bench for arcade_video_timing on a reduced raster, against an
// arithmetic model (position = clocks since reset / CE_DIV).
module tb_arcade_video_timing;

   localparam int HA = 32, HFP = 4, HS = 6, HBP = 6, HT = HA + HFP + HS + HBP;
   localparam int VA = 16, VFP = 3, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
   localparam int CE = 4;
   localparam int FRAME = HT * VT;
`ifdef ARCADE_VIDEO_TESTPAT_EN
   localparam bit TESTPAT = 1'b1;
`else
   localparam bit TESTPAT = 1'b0;
`endif

   logic clk_video = 1'b0;
   always #5 clk_video = ~clk_video;

   logic       reset;
   logic [3:0] hoffset, voffset;
   logic [7:0] RGB_in;
   logic       test_en;

   logic       ce_pix, HBlank, VBlank, HSync, VSync, frame_start;
   logic [8:0] hcount, vcount;
   logic [7:0] RGB_out;

   logic       ce_pix1, HBlank1, VBlank1, frame_start1;
   logic [8:0] hcount1, vcount1;
   logic       hsync1_unused, vsync1_unused;
   logic [7:0] rgb1_unused;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         clk_n    = 0;
   int         hoff_lat = 0;
   int         voff_lat = 0;
   logic [7:0] exp_rgb  = 8'h00;
   logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
   int         hoff_tab [4] = '{7, -8, -3, 5};
   int         voff_tab [4] = '{7, -8, -3, 2};

   arcade_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CE_DIV(CE), .DW(8)
   ) dut (
      .clk_video(clk_video), .reset(reset), .hoffset(hoffset), .voffset(voffset),
      .RGB_in(RGB_in), .test_en(test_en), .ce_pix(ce_pix), .hcount(hcount),
      .vcount(vcount), .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync),
      .VSync(VSync), .frame_start(frame_start), .RGB_out(RGB_out)
   );

   arcade_video_timing #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .CE_DIV(1), .DW(8)
   ) dut1 (
      .clk_video(clk_video), .reset(reset), .hoffset(hoffset), .voffset(voffset),
      .RGB_in(RGB_in), .test_en(test_en), .ce_pix(ce_pix1), .hcount(hcount1),
      .vcount(vcount1), .HBlank(HBlank1), .VBlank(VBlank1), .HSync(hsync1_unused),
      .VSync(vsync1_unused), .frame_start(frame_start1), .RGB_out(rgb1_unused)
   );

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (clk %0d)", tag, obs, exp, clk_n);
      end
   endtask

   function automatic int sx4(input logic [3:0] v);
      return int'($signed(v));
   endfunction

   function automatic int sync_start(input int base, input int off, input int lo, input int hi);
      int v;
      v = base + off;
      if (v < lo) v = lo;
      if (v > hi) v = hi;
      return v;
   endfunction

   function automatic logic [7:0] bar_at(input int hc);
      int idx;
      idx = hc / (HA / 8);
      if (idx > 7) idx = 7;
      return bars[idx];
   endfunction

   task automatic check_outputs();
      int s, hc, vc, hs, vs, hc1, vc1;
      s  = clk_n / CE;
      hc = s % HT;
      vc = (s / HT) % VT;
      hs = sync_start(HA + HFP, hoff_lat, HA, HT - HS);
      vs = sync_start(VA + VFP, voff_lat, VA, VT - VS);
      check_eq("ce_pix",      ce_pix,      (clk_n > 0) && (clk_n % CE == 0));
      check_eq("hcount",      hcount,      hc);
      check_eq("vcount",      vcount,      vc);
      check_eq("HBlank",      HBlank,      hc >= HA);
      check_eq("VBlank",      VBlank,      vc >= VA);
      check_eq("HSync",       HSync,       (hc >= hs) && (hc < hs + HS));
      check_eq("VSync",       VSync,       (vc >= vs) && (vc < vs + VS));
      check_eq("frame_start", frame_start, (s > 0) && (hc == 0) && (vc == 0));
      check_eq("RGB_out",     RGB_out,     exp_rgb);
      hc1 = clk_n % HT;
      vc1 = (clk_n / HT) % VT;
      check_eq("ce1_pix",      ce_pix1,      clk_n > 0);
      check_eq("ce1_hcount",   hcount1,      hc1);
      check_eq("ce1_vcount",   vcount1,      vc1);
      check_eq("ce1_HBlank",   HBlank1,      hc1 >= HA);
      check_eq("ce1_VBlank",   VBlank1,      vc1 >= VA);
      check_eq("ce1_frame",    frame_start1, (clk_n > 0) && (hc1 == 0) && (vc1 == 0));
   endtask

   // Advance one clock: update the model with the inputs seen at the edge, then check.
   task automatic clock_edge();
      int s, hc, vc;
      @(posedge clk_video);
      if (reset) begin
         clk_n    = 0;
         hoff_lat = 0;
         voff_lat = 0;
         exp_rgb  = 8'h00;
      end else begin
         clk_n++;
         if (clk_n % CE == 0) begin
            s  = clk_n / CE;
            hc = s % HT;
            vc = (s / HT) % VT;
            if (hc == 0 && vc == 0) begin
               hoff_lat = sx4(hoffset);
               voff_lat = sx4(voffset);
            end
            if (hc < HA && vc < VA) begin
               exp_rgb = (TESTPAT && test_en) ? bar_at(hc) : RGB_in;
            end else begin
               exp_rgb = 8'h00;
            end
         end
      end
      #1;
      check_outputs();
   endtask

   initial begin
      int chg;
      bit found;
      reset   = 1'b1;
      hoffset = 4'd0;
      voffset = 4'd0;
      RGB_in  = 8'h00;
      test_en = 1'b0;
      repeat (3) clock_edge();
      reset = 1'b0;

      for (int f = 0; f < 4; f++) begin
         chg = int'($urandom_range(FRAME * CE - 1, 0));
         for (int c = 0; c < FRAME * CE; c++) begin
            if (c == chg) begin
               hoffset = 4'(hoff_tab[f]);
               voffset = 4'(voff_tab[f]);
            end
            RGB_in = (f == 0) ? 8'hFF : 8'($urandom);
            if (c % (HT * CE) == 0) test_en = 1'($urandom);
            clock_edge();
         end
      end

      found = 1'b0;
      for (int c = 0; c < FRAME * CE && !found; c++) begin
         RGB_in = 8'($urandom);
         clock_edge();
         found = (hcount == 9'd20) && (vcount == 9'd8) && ce_pix;
      end
      check_eq("midreset_pos_found", found, 1);
      reset = 1'b1;
      clock_edge();
      reset = 1'b0;
      for (int c = 0; c < FRAME * CE + 2000; c++) begin
         RGB_in = 8'($urandom);
         if (c % (HT * CE) == 0) test_en = 1'($urandom);
         clock_edge();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
